multiply_pipe: RTL and testbench
================================

Name: multiply_pipe

Overview:
- Parametrised pipelined integer multiplier execution unit for the integer backend; successor to the fixed 32-bit/4-stage unit.
- Adds generic XLEN and stage count, per-stage bubble-collapsing backpressure from the writeback arbiter, and branch-flush of in-flight ops by sequence number.
- Sits between issue queue and result bus; one op accepted per cycle when not busy.

Parameters:
- XLEN, 32, operand/result width; must be divisible by NUM_STAGES
- NUM_STAGES, 4, partial-product stages; BITS = XLEN/NUM_STAGES multiplier bits per stage
- TAG_W, 7, destination tag width
- SQN_W, 7, sequence number width (wrapping, compared signed)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- IN_valid  in  1  op presented
- IN_opcode  in  2  0=MUL, 1=MULH (s*s), 2=MULHSU (s*u), 3=MULHU (u*u)
- IN_srcA  in  XLEN  multiplicand
- IN_srcB  in  XLEN  multiplier
- IN_tagDst  in  TAG_W  destination tag
- IN_sqN  in  SQN_W  op sequence number
- IN_branchValid  in  1  mispredict flush this cycle
- IN_branchSqN  in  SQN_W  sqN of the mispredicting branch
- IN_stall  in  1  writeback cannot take OUT this cycle
- OUT_busy  out  1  stage 0 cannot accept this cycle (combinational)
- OUT_valid  out  1  result valid
- OUT_result  out  XLEN  result
- OUT_tagDst  out  TAG_W  result tag
- OUT_sqN  out  SQN_W  result sqN

Behaviour:
- Slots: S0 (input register), P1..PN (N=NUM_STAGES), O (output register); each has a valid bit and carries tag, sqN, opcode flags, |A|, |B|, 2*XLEN accumulator, invert flag.
- S0 capture: |A| = A negated if signed and negative; same for B. MULH: invert = A[msb]^B[msb]; MULHSU: invert = A[msb], B unsigned; MULHU/MUL: invert = 0, both unsigned. Accumulator cleared.
- Stage Pi+1 from Pi/S0: acc += (|A| * |B|[BITS*i +: BITS]) << (BITS*i), 2*XLEN-bit arithmetic, no truncation.
- O from PN: MUL -> acc[XLEN-1:0], ignores invert. Others -> invert ? ~acc[2X-1:X] + (acc[X-1:0]==0) : acc[2X-1:X].
- Latency: op accepted in cycle t -> OUT_valid in cycle t+NUM_STAGES+2 if never stalled (default 6). Throughput 1/cycle.
- Advance rule: O holds while IN_stall && OUT_valid. Slot k advances if slot k+1 is empty, advancing, or being flushed this cycle. A non-advancing valid slot holds contents unchanged (no accumulate). Bubbles collapse.
- OUT_busy = S0 valid && S0 not advancing. Accept iff IN_valid && !OUT_busy. Issuer must not present while busy; IN_valid while busy is ignored.
- Flush: when IN_branchValid, every valid slot (S0..PN, O, including held/stalled ones) with $signed(sqN - IN_branchSqN) > 0 is cleared in that cycle. An incoming op meeting the same condition is not captured. Equal sqN survives. Flush applies whatever the stall state.
- Simultaneous flush and advance: a flushed slot's successor sees it as empty. A surviving slot behind it may advance into the freed position the same cycle.
- Reset: all valid bits 0. OUT_valid=0, OUT_busy=0; data outputs don't-care (driven 0). Reset mid-operation discards all in-flight ops.
- OUT_result/tag/sqN are stable while OUT_valid && IN_stall.

Optional Feature:
- MULTIPLY_PIPE_PERF_EN defined: extra outputs OUT_cntIssued[31:0] (ops accepted) and OUT_cntFlushed[31:0] (ops killed in any slot, plus rejected incoming flushed ops). Both are wrapping, reset to 0, and count flushes of several slots in one cycle with the full popcount.
- Undefined: ports and counters absent; remaining behaviour identical.

Test Plan:
- XLEN=32, N=4: MUL 0xFFFFFFFF*0x2 -> OUT_result 0xFFFFFFFE at cycle t+6. MULHU same operands -> 0x00000001. MULH same operands -> 0xFFFFFFFF. MULHSU -> 0xFFFFFFFF.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULH -3*5 -> 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- 6 back-to-back ops, IN_stall high for 3 cycles once first is in O -> OUT holds op0; pipeline compresses; OUT_busy rises only once S0 is blocked. After release all 6 emerge in order, none lost or duplicated.
- Ops sqN 10,11,12 in flight; branch sqN=11 -> only sqN 12 killed, 10 and 11 complete. Repeat with branch sqN=126 vs op sqN=1 (wrap) -> op killed.
- Flush during stall with O holding a younger op -> OUT_valid drops next cycle. Incoming op with younger sqN in the flush cycle -> never output.
- rst asserted with 4 ops in flight -> OUT_valid=0 for all following cycles until new issue. With MULTIPLY_PIPE_PERF_EN, counters read 0.

Source files
------------

// File: rtl/multiply_pipe.sv
// multiply_pipe: pipelined integer multiplier (MUL/MULH/MULHSU/MULHU) between issue queue and result bus.
// Latency: op accepted in cycle t appears on OUT_* in cycle t+NUM_STAGES+2; one op per cycle sustained.
// Backpressure: IN_stall freezes the output register; upstream slots keep collapsing bubbles until S0 is blocked (OUT_busy).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   IN_valid/opcode/srcA/srcB/tagDst/sqN   op issue (opcode 0=MUL 1=MULH 2=MULHSU 3=MULHU)
//   IN_branchValid/branchSqN kill every in-flight or incoming op strictly younger than the branch
//   IN_stall                 writeback cannot take OUT this cycle
//   OUT_busy                 S0 is occupied and cannot move on (combinational)
//   OUT_valid/result/tagDst/sqN            result
//   Optional (MULTIPLY_PIPE_PERF_EN): OUT_cntIssued, OUT_cntFlushed event counters
module multiply_pipe #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 7,
  parameter int SQN_W      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_valid,
  input  logic [1:0]       IN_opcode,
  input  logic [XLEN-1:0]  IN_srcA,
  input  logic [XLEN-1:0]  IN_srcB,
  input  logic [TAG_W-1:0] IN_tagDst,
  input  logic [SQN_W-1:0] IN_sqN,
  input  logic             IN_branchValid,
  input  logic [SQN_W-1:0] IN_branchSqN,
  input  logic             IN_stall,
  output logic             OUT_busy,
  output logic             OUT_valid,
  output logic [XLEN-1:0]  OUT_result,
  output logic [TAG_W-1:0] OUT_tagDst,
  output logic [SQN_W-1:0] OUT_sqN
`ifdef MULTIPLY_PIPE_PERF_EN
  ,
  output logic [31:0]      OUT_cntIssued,
  output logic [31:0]      OUT_cntFlushed
`endif
);

  localparam int N    = NUM_STAGES;
  localparam int BITS = XLEN / NUM_STAGES;
  localparam int AW   = 2 * XLEN;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  // One pipeline slot: operands are kept as magnitudes, the sign of the
  // final high word is restored at the output via the invert flag.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SQN_W-1:0] sqn;
    logic [1:0]       op;
    logic             inv;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [AW-1:0]    acc;
  } slot_t;

  // Index 0 is S0 (input register), index k (1..N) is partial-product stage Pk.
  slot_t            slot_q [N+1];
  slot_t            slot_d [N+1];
  logic [N:0]       vld_q;
  logic [N:0]       vld_d;

  logic             o_vld_q;
  logic             o_vld_d;
  logic [XLEN-1:0]  o_res_q;
  logic [XLEN-1:0]  o_res_d;
  logic [TAG_W-1:0] o_tag_q;
  logic [TAG_W-1:0] o_tag_d;
  logic [SQN_W-1:0] o_sqn_q;
  logic [SQN_W-1:0] o_sqn_d;

  slot_t            in_slot;
  logic             a_sgn;
  logic             b_sgn;
  logic [AW-1:0]    stage_acc [N];
  logic [XLEN-1:0]  final_res;

  logic [N:0]       flush_p;
  logic             flush_o;
  logic             o_free;
  logic [N:0]       succ_free;
  logic [N:0]       move;
  logic             busy;
  logic             accept;
  logic             kill_in;
  logic             capture;

  // Wrapping sequence compare: sqn is younger than br when (sqn - br),
  // read as a signed SQN_W-bit number, is strictly positive.
  function automatic logic is_younger(input logic [SQN_W-1:0] sqn,
                                      input logic [SQN_W-1:0] br);
    logic [SQN_W-1:0] diff;
    diff = sqn - br;
    return !diff[SQN_W-1] && (diff != '0);
  endfunction

  // ---------------------------------------------------------------------
  // S0 capture: take magnitudes of signed operands, remember result sign.
  // ---------------------------------------------------------------------
  always_comb begin
    in_slot     = '0;
    a_sgn       = (IN_opcode == OP_MULH) || (IN_opcode == OP_MULHSU);
    b_sgn       = (IN_opcode == OP_MULH);
    in_slot.tag = IN_tagDst;
    in_slot.sqn = IN_sqN;
    in_slot.op  = IN_opcode;
    in_slot.a   = (a_sgn && IN_srcA[XLEN-1]) ? -IN_srcA : IN_srcA;
    in_slot.b   = (b_sgn && IN_srcB[XLEN-1]) ? -IN_srcB : IN_srcB;
    if (IN_opcode == OP_MULH) begin
      in_slot.inv = IN_srcA[XLEN-1] ^ IN_srcB[XLEN-1];
    end else if (IN_opcode == OP_MULHSU) begin
      in_slot.inv = IN_srcA[XLEN-1];
    end else begin
      in_slot.inv = 1'b0;
    end
    in_slot.acc = '0;
  end

  // ---------------------------------------------------------------------
  // Partial products: the slot at index k adds the k-th BITS-wide chunk of
  // |B| times |A|, shifted into place, on its way to index k+1.
  // ---------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < N; k++) begin
      stage_acc[k] = slot_q[k].acc
                   + ((AW'(slot_q[k].a) * AW'(slot_q[k].b[BITS*k +: BITS])) << (BITS*k));
    end
  end

  // Final result from PN. A negative high word is ~hi + carry, where the
  // carry out of the low half of the two's complement is set only if lo == 0.
  always_comb begin
    final_res = slot_q[N].acc[AW-1:XLEN];
    if (slot_q[N].op == OP_MUL) begin
      final_res = slot_q[N].acc[XLEN-1:0];
    end else if (slot_q[N].inv) begin
      final_res = ~slot_q[N].acc[AW-1:XLEN] + XLEN'(slot_q[N].acc[XLEN-1:0] == '0);
    end
  end

  // ---------------------------------------------------------------------
  // Flow control. Advance decisions ripple from the output back to S0 so a
  // slot may move into a position vacated (by advance or flush) this cycle.
  // A slot being flushed never moves; its successor sees it as empty.
  // ---------------------------------------------------------------------
  always_comb begin
    flush_p = '0;
    for (int k = 0; k <= N; k++) begin
      flush_p[k] = IN_branchValid && vld_q[k] && is_younger(slot_q[k].sqn, IN_branchSqN);
    end
    flush_o = IN_branchValid && o_vld_q && is_younger(o_sqn_q, IN_branchSqN);
    o_free  = !o_vld_q || !IN_stall || flush_o;

    succ_free    = '0;
    move         = '0;
    succ_free[N] = o_free;
    move[N]      = vld_q[N] && !flush_p[N] && succ_free[N];
    for (int k = N - 1; k >= 0; k--) begin
      succ_free[k] = !vld_q[k+1] || flush_p[k+1] || move[k+1];
      move[k]      = vld_q[k] && !flush_p[k] && succ_free[k];
    end

    // Busy deliberately ignores the flush of S0 itself, keeping the branch
    // compare off the busy path back to the issue queue.
    busy    = vld_q[0] && !succ_free[0];
    accept  = IN_valid && !busy;
    kill_in = IN_branchValid && is_younger(IN_sqN, IN_branchSqN);
    capture = accept && !kill_in;
  end

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    vld_d    = '0;
    vld_d[0] = capture || (vld_q[0] && !flush_p[0] && !move[0]);
    slot_d[0] = capture ? in_slot : slot_q[0];

    for (int k = 1; k <= N; k++) begin
      vld_d[k]  = move[k-1] || (vld_q[k] && !flush_p[k] && !move[k]);
      slot_d[k] = slot_q[k];
      if (move[k-1]) begin
        slot_d[k]     = slot_q[k-1];
        slot_d[k].acc = stage_acc[k-1];
      end
    end

    o_vld_d = move[N] || (o_vld_q && IN_stall && !flush_o);
    o_res_d = o_res_q;
    o_tag_d = o_tag_q;
    o_sqn_d = o_sqn_q;
    if (move[N]) begin
      o_res_d = final_res;
      o_tag_d = slot_q[N].tag;
      o_sqn_d = slot_q[N].sqn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      o_vld_q <= 1'b0;
      o_res_q <= '0;
      o_tag_q <= '0;
      o_sqn_q <= '0;
    end else begin
      vld_q   <= vld_d;
      o_vld_q <= o_vld_d;
      o_res_q <= o_res_d;
      o_tag_q <= o_tag_d;
      o_sqn_q <= o_sqn_d;
    end
  end

  // Slot payloads need no reset: they are qualified by vld_q.
  always_ff @(posedge clk) begin
    for (int k = 0; k <= N; k++) begin
      slot_q[k] <= slot_d[k];
    end
  end

  assign OUT_busy   = busy;
  assign OUT_valid  = o_vld_q;
  assign OUT_result = o_res_q;
  assign OUT_tagDst = o_tag_q;
  assign OUT_sqN    = o_sqn_q;

`ifdef MULTIPLY_PIPE_PERF_EN
  logic [31:0] cnt_issued_q;
  logic [31:0] cnt_flushed_q;

  // Flushed count includes an accepted op killed on arrival.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_issued_q  <= '0;
      cnt_flushed_q <= '0;
    end else begin
      cnt_issued_q  <= cnt_issued_q + 32'(accept);
      cnt_flushed_q <= cnt_flushed_q + 32'($countones({flush_p, flush_o, accept && kill_in}));
    end
  end

  assign OUT_cntIssued  = cnt_issued_q;
  assign OUT_cntFlushed = cnt_flushed_q;
`endif

endmodule

// File: tb/tb_multiply_pipe.sv
module tb_multiply_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_valid;
  logic [1:0]  IN_opcode;
  logic [31:0] IN_srcA;
  logic [31:0] IN_srcB;
  logic [6:0]  IN_tagDst;
  logic [6:0]  IN_sqN;
  logic        IN_branchValid;
  logic [6:0]  IN_branchSqN;
  logic        IN_stall;
  logic        OUT_busy;
  logic        OUT_valid;
  logic [31:0] OUT_result;
  logic [6:0]  OUT_tagDst;
  logic [6:0]  OUT_sqN;
`ifdef MULTIPLY_PIPE_PERF_EN
  logic [31:0] cnt_issued;
  logic [31:0] cnt_flushed;
`endif

  always #5 clk = ~clk;

  multiply_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .IN_valid       (IN_valid),
    .IN_opcode      (IN_opcode),
    .IN_srcA        (IN_srcA),
    .IN_srcB        (IN_srcB),
    .IN_tagDst      (IN_tagDst),
    .IN_sqN         (IN_sqN),
    .IN_branchValid (IN_branchValid),
    .IN_branchSqN   (IN_branchSqN),
    .IN_stall       (IN_stall),
    .OUT_busy       (OUT_busy),
    .OUT_valid      (OUT_valid),
    .OUT_result     (OUT_result),
    .OUT_tagDst     (OUT_tagDst),
    .OUT_sqN        (OUT_sqN)
`ifdef MULTIPLY_PIPE_PERF_EN
    ,
    .OUT_cntIssued  (cnt_issued),
    .OUT_cntFlushed (cnt_flushed)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [6:0]  tag;
    logic [6:0]  sqn;
  } exp_t;

  exp_t sb[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   n_issued  = 0;
  int   n_flushed = 0;
  int   n_out     = 0;

  // Reference: full 64-bit product of sign/zero-extended operands.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'd0:    begin p = {32'b0, a} * {32'b0, b};               return p[31:0];  end
      2'd1:    begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   return p[63:32]; end
      2'd2:    begin p = {{32{a[31]}}, a} * {32'b0, b};         return p[63:32]; end
      default: begin p = {32'b0, a} * {32'b0, b};               return p[63:32]; end
    endcase
  endfunction

  // sqn is younger than br if it lies 1..63 steps ahead on the 128-entry ring.
  function automatic bit model_younger(input logic [6:0] s, input logic [6:0] br);
    int d;
    d = (int'(s) - int'(br) + 128) % 128;
    return (d >= 1) && (d <= 63);
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Compare a result the cycle it is handed to writeback, then advance one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (!rst && OUT_valid && !IN_stall) begin
      chk("out_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_sqn", 64'(OUT_sqN), 64'(e.sqn));
        chk("out_tag", 64'(OUT_tagDst), 64'(e.tag));
        chk("out_result", 64'(OUT_result), 64'(e.res));
        n_out++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] tag, input logic [6:0] sqn);
    exp_t e;
    IN_valid  = 1'b1;
    IN_opcode = op;
    IN_srcA   = a;
    IN_srcB   = b;
    IN_tagDst = tag;
    IN_sqN    = sqn;
    #1;
    chk("busy_at_issue", 64'(OUT_busy), 64'd0);
    e.res = model(op, a, b);
    e.tag = tag;
    e.sqn = sqn;
    sb.push_back(e);
    n_issued++;
    tick();
    IN_valid = 1'b0;
  endtask

  task automatic model_flush(input logic [6:0] br);
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (model_younger(sb[i].sqn, br)) n_flushed++;
      else keep.push_back(sb[i]);
    end
    sb = keep;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  t_op [6];
    logic [31:0] t_a  [6];
    logic [31:0] t_b  [6];
    logic [6:0]  sq;
    int          out0;
    int          w;

    rst = 1'b1; IN_valid = 1'b0; IN_opcode = '0; IN_srcA = '0; IN_srcB = '0;
    IN_tagDst = '0; IN_sqN = '0; IN_branchValid = 1'b0; IN_branchSqN = '0; IN_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(OUT_valid), 64'd0);
    chk("rst_busy", 64'(OUT_busy), 64'd0);
    chk("rst_result", 64'(OUT_result), 64'd0);
`ifdef MULTIPLY_PIPE_PERF_EN
    chk("rst_cnt_issued", 64'(cnt_issued), 64'd0);
    chk("rst_cnt_flushed", 64'(cnt_flushed), 64'd0);
`endif
    rst = 1'b0;
    tick();

    // Latency: accepted in cycle t, valid in cycle t+6.
    issue(2'd0, 32'hFFFF_FFFF, 32'h2, 7'd1, 7'd1);
    for (int i = 1; i <= 6; i++) begin
      chk("latency_valid", 64'(OUT_valid), 64'(i == 6));
      if (i < 6) tick();
    end
    chk("mul_low_const", 64'(OUT_result), 64'hFFFF_FFFE);
    drain(3);

    // Directed corner operands back to back, then random ones.
    t_op[0] = 2'd3; t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'h2;
    t_op[1] = 2'd1; t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'h2;
    t_op[2] = 2'd2; t_a[2] = 32'hFFFF_FFFF; t_b[2] = 32'h2;
    t_op[3] = 2'd1; t_a[3] = 32'h8000_0000; t_b[3] = 32'h8000_0000;
    t_op[4] = 2'd1; t_a[4] = 32'hFFFF_FFFD; t_b[4] = 32'h5;
    t_op[5] = 2'd3; t_a[5] = 32'hFFFF_FFFF; t_b[5] = 32'hFFFF_FFFF;
    sq = 7'd2;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 7'(i + 8), sq);
      sq++;
    end
    for (int i = 0; i < 16; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, $urandom, 7'($urandom), sq);
      sq++;
    end
    drain(10);
    chk("directed_drained", 64'(sb.size()), 64'd0);

    // Stall with six ops in flight: O holds op0, pipeline compresses, S0 blocks.
    out0 = n_out;
    for (int i = 0; i < 6; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, $urandom, 7'(40 + i), sq);
      sq++;
    end
    IN_stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("stall_valid", 64'(OUT_valid), 64'd1);
      chk("stall_sqn_held", 64'(OUT_sqN), 64'(sb[0].sqn));
      chk("stall_res_held", 64'(OUT_result), 64'(sb[0].res));
      chk("stall_busy", 64'(OUT_busy), 64'd1);
      tick();
    end
    IN_stall = 1'b0;
    #1;
    chk("busy_release", 64'(OUT_busy), 64'd0);
    drain(10);
    chk("stall_all_out", 64'(n_out - out0), 64'd6);
    chk("stall_drained", 64'(sb.size()), 64'd0);

    // Branch flush: sqN 10,11,12 in flight, branch 11 kills only 12.
    out0 = n_out;
    issue(2'd0, 32'd3, 32'd7, 7'd20, 7'd10);
    issue(2'd1, 32'hFFFF_FFF0, 32'd9, 7'd21, 7'd11);
    issue(2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 7'd22, 7'd12);
    IN_branchValid = 1'b1;
    IN_branchSqN   = 7'd11;
    model_flush(7'd11);
    tick();
    IN_branchValid = 1'b0;
    drain(10);
    chk("flush_survivors", 64'(n_out - out0), 64'd2);
    chk("flush_drained", 64'(sb.size()), 64'd0);

    // Wrap: op sqN 1 is younger than branch sqN 126.
    out0 = n_out;
    issue(2'd0, 32'd5, 32'd6, 7'd30, 7'd1);
    IN_branchValid = 1'b1;
    IN_branchSqN   = 7'd126;
    model_flush(7'd126);
    tick();
    IN_branchValid = 1'b0;
    drain(10);
    chk("wrap_killed", 64'(n_out - out0), 64'd0);

    // Flush while stalled, O holding a younger op, plus a younger op arriving.
    out0 = n_out;
    IN_stall = 1'b1;
    issue(2'd3, 32'd100, 32'd200, 7'd31, 7'd20);
    w = 0;
    while (!OUT_valid && w < 20) begin
      tick();
      w++;
    end
    chk("stall_o_reached", 64'(OUT_valid), 64'd1);
    IN_branchValid = 1'b1;
    IN_branchSqN   = 7'd19;
    IN_valid  = 1'b1;
    IN_opcode = 2'd0;
    IN_srcA   = 32'd9;
    IN_srcB   = 32'd9;
    IN_tagDst = 7'd32;
    IN_sqN    = 7'd21;
    n_issued++;
    model_flush(7'd19);
    n_flushed++;
    #1;
    chk("busy_in_flush", 64'(OUT_busy), 64'd0);
    tick();
    IN_valid       = 1'b0;
    IN_branchValid = 1'b0;
    chk("o_flushed_drop", 64'(OUT_valid), 64'd0);
    IN_stall = 1'b0;
    drain(10);
    chk("no_out_after_flush", 64'(n_out - out0), 64'd0);
`ifdef MULTIPLY_PIPE_PERF_EN
    chk("cnt_issued", 64'(cnt_issued), 64'(n_issued));
    chk("cnt_flushed", 64'(cnt_flushed), 64'(n_flushed));
`endif

    // Reset with four ops in flight discards them all.
    for (int i = 0; i < 4; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, $urandom, 7'(50 + i), sq);
      sq++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
`ifdef MULTIPLY_PIPE_PERF_EN
    chk("rst_mid_cnt_issued", 64'(cnt_issued), 64'd0);
    chk("rst_mid_cnt_flushed", 64'(cnt_flushed), 64'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      chk("rst_mid_valid", 64'(OUT_valid), 64'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
